// File: rtl/ppl_stage_buf.sv
// ppl_stage_buf: 2-entry skid-buffered pipeline stage register with hold/flush control.
// Optional saturating stall/flush counters are built when PPL_STAGE_PERF_EN is defined.
module ppl_stage_buf #(
  parameter int             WIDTH      = 16,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}},
  parameter int             CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef PPL_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_run;
  logic             w_accept;
  logic             w_fire;

  // Ready depends only on registered state and local stage controls, never on out_ready.
  assign w_run     = ~hold & ~flush;
  assign in_ready  = w_run & (r_state != FULL);
  assign out_valid = w_run & (r_state != EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_fire    = out_valid & out_ready;
  assign out_data  = r_main;
  assign occupancy = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_main  <= BUBBLE_VAL;
      r_skid  <= BUBBLE_VAL;
    end else if (flush) begin
      r_state <= EMPTY;
      r_main  <= BUBBLE_VAL;
      r_skid  <= BUBBLE_VAL;
    end else if (!hold) begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_state <= BUSY;
            r_main  <= in_data;
          end
        end
        BUSY: begin
          if (w_accept && w_fire) begin
            r_main <= in_data;
          end else if (w_accept) begin
            r_state <= FULL;
            r_skid  <= in_data;
          end else if (w_fire) begin
            r_state <= EMPTY;
            r_main  <= BUBBLE_VAL;
          end
        end
        FULL: begin
          // Skid drains into main before any new input is taken, preserving order.
          if (w_fire) begin
            r_state <= BUSY;
            r_main  <= r_skid;
            r_skid  <= BUBBLE_VAL;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_main  <= BUBBLE_VAL;
          r_skid  <= BUBBLE_VAL;
        end
      endcase
    end
  end

`ifdef PPL_STAGE_PERF_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = (r_state != EMPTY) & ~flush & (hold | ~out_ready);
  assign w_flush_inc = flush & (r_state != EMPTY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
      if (w_flush_inc && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  // Counter width only matters when the counters exist; still reject nonsense values.
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end
`endif

endmodule

// File: tb/tb_ppl_stage_buf.sv
// Bench for ppl_stage_buf: directed test-plan steps plus randomized traffic
// checked against a queue-based reference model.
module tb_ppl_stage_buf;
  localparam int W = 16;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst, flush, hold, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occupancy;
`ifdef PPL_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] q[$];

  ppl_stage_buf #(.WIDTH(W), .BUBBLE_VAL('0), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PPL_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model view: a FIFO of at most two items gated by hold/flush.
  function automatic logic m_in_ready();
    return !hold && !flush && (q.size() < 2);
  endfunction
  function automatic logic m_out_valid();
    return !hold && !flush && (q.size() > 0);
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_ivld"}, {31'd0, out_valid}, {31'd0, m_out_valid()});
    chk({tag, "_irdy"}, {31'd0, in_ready}, {31'd0, m_in_ready()});
    chk({tag, "_occ"}, {30'd0, occupancy}, q.size());
    chk({tag, "_data"}, {16'd0, out_data}, (q.size() > 0) ? {16'd0, q[0]} : 32'd0);
  endtask

  // One clock: check against the model mid-cycle, advance the model, cross the edge.
  task automatic cyc(input string tag);
    logic acc, fire;
    @(negedge clk);
    check_model(tag);
    acc  = in_valid && m_in_ready();
    fire = m_out_valid() && out_ready;
    if (flush) q.delete();
    else if (!hold) begin
      if (fire) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 0; hold = 0; in_valid = 0; out_ready = 0; in_data = '0;
    do_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_occ", {30'd0, occupancy}, 0);
    chk("rst_data", {16'd0, out_data}, 0);

    // Streaming at full rate
    out_ready = 1; in_valid = 1;
    in_data = 16'h0011; cyc("s0");
    in_data = 16'h0022; #1;
    chk("str_d1", {16'd0, out_data}, 32'h0011);
    chk("str_occ1", {30'd0, occupancy}, 1);
    chk("str_rdy1", {31'd0, in_ready}, 1);
    cyc("s1");
    in_data = 16'h0033; #1;
    chk("str_d2", {16'd0, out_data}, 32'h0022);
    chk("str_occ2", {30'd0, occupancy}, 1);
    cyc("s2");
    in_valid = 0; #1;
    chk("str_d3", {16'd0, out_data}, 32'h0033);
    chk("str_occ3", {30'd0, occupancy}, 1);
    cyc("s3");
    chk("str_empty", {30'd0, occupancy}, 0);

    // Backpressure into the skid entry
    out_ready = 0; in_valid = 1;
    in_data = 16'hAAAA; cyc("b0");
    in_data = 16'hBBBB; cyc("b1");
    in_valid = 0; #1;
    chk("bp_occ2", {30'd0, occupancy}, 2);
    chk("bp_rdy0", {31'd0, in_ready}, 0);
    out_ready = 1; #1;
    chk("bp_first", {16'd0, out_data}, 32'hAAAA);
    cyc("b2");
    chk("bp_second", {16'd0, out_data}, 32'hBBBB);
    chk("bp_occ1", {30'd0, occupancy}, 1);
    cyc("b3");
    chk("bp_occ0", {30'd0, occupancy}, 0);
    chk("bp_bubble", {16'd0, out_data}, 32'h0000);

    // Hold freezes a full buffer
    out_ready = 0; in_valid = 1;
    in_data = 16'h1234; cyc("h0");
    in_data = 16'h5678; cyc("h1");
    in_valid = 0; hold = 1; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ovld", {31'd0, out_valid}, 0);
      chk("hold_irdy", {31'd0, in_ready}, 0);
      chk("hold_occ", {30'd0, occupancy}, 2);
      chk("hold_data", {16'd0, out_data}, 32'h1234);
      cyc("h2");
    end
    hold = 0; #1;
    chk("hold_rel_vld", {31'd0, out_valid}, 1);
    chk("hold_rel_data", {16'd0, out_data}, 32'h1234);
    cyc("h3");
    chk("hold_next", {16'd0, out_data}, 32'h5678);
    cyc("h4");

    // Flush beats hold and drops the concurrent input
    out_ready = 0; in_valid = 1;
    in_data = 16'h0101; cyc("f0");
    in_data = 16'h0202; cyc("f1");
    flush = 1; hold = 1; in_data = 16'h9999; #1;
    chk("fl_irdy", {31'd0, in_ready}, 0);
    chk("fl_ovld", {31'd0, out_valid}, 0);
    cyc("f2");
    flush = 0; hold = 0; in_valid = 0; out_ready = 1; #1;
    chk("fl_occ", {30'd0, occupancy}, 0);
    chk("fl_data", {16'd0, out_data}, 32'h0000);
    chk("fl_ovld2", {31'd0, out_valid}, 0);
    cyc("f3");

    // Asynchronous reset while busy
    out_ready = 0; in_valid = 1; in_data = 16'h00FF; cyc("r0");
    in_valid = 0;
    chk("ar_busy", {16'd0, out_data}, 32'h00FF);
    #1 rst = 1; q.delete();
    #1;
    chk("ar_ovld", {31'd0, out_valid}, 0);
    chk("ar_data", {16'd0, out_data}, 32'h0000);
    chk("ar_occ", {30'd0, occupancy}, 0);
    @(negedge clk) rst = 0;
    #1;
    chk("ar_irdy", {31'd0, in_ready}, 1);
    @(posedge clk); #1;

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      hold      = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = W'($urandom);
      cyc("rnd");
    end
    flush = 0; hold = 0; in_valid = 0;

`ifdef PPL_STAGE_PERF_EN
    do_reset();
    chk("pf_stall0", {28'd0, stall_cnt}, 0);
    chk("pf_flush0", {28'd0, flush_cnt}, 0);
    out_ready = 0; in_valid = 1; in_data = 16'h4242; cyc("p0");
    in_valid = 0; hold = 1;
    repeat (20) cyc("p1");
    chk("pf_stall_sat", {28'd0, stall_cnt}, 32'hF);
    hold = 0; flush = 1; cyc("p2");
    chk("pf_flush1", {28'd0, flush_cnt}, 1);
    cyc("p3");
    chk("pf_flush_empty", {28'd0, flush_cnt}, 1);
    flush = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
